// File: rtl/mem_pkg.sv
// Shared definitions for the L2 memory-port responder: line/address widths and the
// responder's state and operation encodings.
package mem_pkg;

    localparam int unsigned LINE_W  = 128;
    localparam int unsigned MADDR_W = 28;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp,
        StGap
    } resp_state_e;

    typedef enum logic {
        OpRd,
        OpWr
    } mem_op_e;

endpackage

// File: rtl/mem_line_array.sv
// Single-port synchronous line RAM: 2^IDX_W lines of LINE_W bits, write enable and a
// registered read port that holds its value until the next read.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int unsigned IDX_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    localparam int unsigned Depth = 1 << IDX_W;

    // Storage is deliberately not reset; contents are undefined until written.
    logic [LINE_W-1:0] mem_array [Depth];
    logic [LINE_W-1:0] rdata_q, rdata_d;

    // Read register only loads on an explicit read, so writes never disturb it.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_array[idx];
        end
    end

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[idx] <= wdata;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/l2_mem_responder.sv
// Memory-side responder for the L2 miss/writeback port. Accepts a line read or write,
// waits a fixed LATENCY, commits on the WAIT->RESP edge and pulses mem_ready once.
// Optional feature: define L2_MEM_STATS_EN to add saturating rd_cnt/wr_cnt outputs.
module l2_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned IDX_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [MADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]  mem_wdata,
    output logic [LINE_W-1:0]  mem_rdata,
    output logic               mem_ready
`ifdef L2_MEM_STATS_EN
    ,
    output logic [15:0]        rd_cnt,
    output logic [15:0]        wr_cnt
`endif
);

    // Two of the LATENCY cycles are the IDLE accept cycle and the commit edge itself.
    localparam logic [7:0] CntLoad = 8'(LATENCY - 2);

    resp_state_e state_q, state_d;
    mem_op_e     op_q, op_d;
    logic [7:0]  cnt_q, cnt_d;

    logic req_held;
    logic commit;
    logic arr_we;
    logic arr_re;

    // Upper address bits alias onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[MADDR_W-1:IDX_W];

    // The request line that matters is the one belonging to the latched op.
    assign req_held = (op_q == OpWr) ? mem_write : mem_read;

    // State, op and latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpRd;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept, count down (abort if request drops), respond, dead cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_write || mem_read) begin
                    state_d = StWait;
                    op_d    = mem_write ? OpWr : OpRd;
                    cnt_d   = CntLoad;
                end
            end
            StWait: begin
                if (!req_held) begin
                    state_d = StIdle;
                end else if (cnt_q == 8'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp:  state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: commit strobes on the WAIT->RESP edge (never on a reset edge), ready in RESP.
    always_comb begin
        commit    = (state_q == StWait) && req_held && (cnt_q == 8'd0) && !reset;
        arr_we    = commit && (op_q == OpWr);
        arr_re    = commit && (op_q == OpRd);
        mem_ready = (state_q == StResp);
    end

    mem_line_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (mem_addr[IDX_W-1:0]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

`ifdef L2_MEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    // Completed-transfer counters, saturating; aborted requests never reach commit.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (arr_re && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (arr_we && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    // No statistics counters in this build.
`endif

endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Main-memory responder on the L2 cache's memory port: accepts 128-bit line reads and writes issued on `mem_read`/`mem_write`/`mem_addr`/`mem_wdata` and answers each with a one-cycle `mem_ready` pulse after a fixed latency. It is the memory-side end of the L2 miss/writeback protocol, used both as the synthesizable backing-store model in the processor testbench and as the stand-in for the external memory controller.

## Interface
Parameters:
- `LATENCY`, 8, cycles from request acceptance to `mem_ready`; legal range 2..255.
- `IDX_W`, 10, line-index bits used from `mem_addr`; depth = 2^IDX_W lines.

Ports:
- `clk` in 1 — clock.
- `reset` in 1 — reset, synchronous, active-high; clock clk.
- `mem_read` in 1 — line read request, level, held by master until `mem_ready`.
- `mem_write` in 1 — line write request, level, held by master until `mem_ready`.
- `mem_addr` in 28 — line address (word address >> 2); bits [IDX_W-1:0] index the array.
- `mem_wdata` in 128 — write line.
- `mem_rdata` out 128 — read line, registered.
- `mem_ready` out 1 — one-cycle completion pulse.

## Operation
- States: IDLE, WAIT, RESP, GAP.
- IDLE: if `mem_write` or `mem_read` high → WAIT, latch op (write has priority if both high), load `cnt` = LATENCY-2. Address/data not latched here.
- WAIT: if the latched op's request line drops → IDLE, no commit, no ready (abort). Else if `cnt`==0 → RESP; else `cnt` decrements.
- Transition WAIT→RESP edge: sample `mem_addr` and `mem_wdata` (current values; master may present valid wdata only from its second request cycle). Write: array[idx] ← `mem_wdata`. Read: `mem_rdata` ← array[idx]. `mem_ready` ← 1.
- RESP: `mem_ready`=1 for exactly this cycle → GAP. Requests ignored.
- GAP: one dead cycle (master's registered request is still high here); requests ignored → IDLE.
- `mem_rdata` holds last read value until next read completes; unchanged by writes.
- Upper address bits [27:IDX_W] ignored (aliasing allowed).
- Array contents not cleared by reset; undefined until written.

## Timing
- Request first seen high at cycle 0 (IDLE) → `mem_ready` high in cycle LATENCY, low in LATENCY+1; next request can be accepted no earlier than cycle LATENCY+2.
- Read data valid in the `mem_ready` cycle; write visible to a read accepted afterwards.
- Back-to-back writeback→allocate: master drops request one cycle after ready, re-asserts the following cycle; responder in IDLE by then.
- Reset values: `mem_ready`=0, `mem_rdata`=0, state IDLE, `cnt`=0. Reset mid-operation aborts; no array write occurs on the reset edge.
- `cnt` is 8 bits; no wrap (loaded ≤ 253, counts down to 0 only).

## Configuration
- `L2_MEM_STATS_EN`: defined → adds outputs `rd_cnt` out 16 and `wr_cnt` out 16, incremented on each completed read/write (WAIT→RESP edge), saturating at 16'hFFFF, reset to 0; aborted requests not counted. Undefined → ports and counters absent, behaviour otherwise identical.

## Structure
- Shared package `mem_pkg`: `LINE_W`=128, `MADDR_W`=28, responder state enum (IDLE/WAIT/RESP/GAP), op enum (RD/WR).
- One sub-module `mem_line_array`: single-port synchronous 2^IDX_W × 128 RAM, write enable + registered read; responder owns FSM, counter, stats.

## Test plan
- Write 128'hA5..A5 to addr 0x0000010, then read addr 0x0000010, LATENCY=8 → `mem_ready` at cycle 8 of each; read returns A5..A5.
- Write with `mem_wdata`=0 in cycle 0 and 128'h1234 from cycle 1 → read-back returns 128'h1234.
- `mem_read` and `mem_write` both high, addr 5, wdata 128'hFF → treated as write; subsequent read of 5 returns 128'hFF, `mem_rdata` unchanged during the write.
- Drop `mem_read` at cycle 3 of a LATENCY=8 read → no `mem_ready`, state IDLE at cycle 4; `rd_cnt` unchanged.
- Assert `reset` at cycle 5 of a write to addr 7 (prior contents 128'h1) → `mem_ready` never pulses, read of 7 returns 128'h1.
- With `L2_MEM_STATS_EN`, 3 reads + 2 writes → `rd_cnt`=3, `wr_cnt`=2; LATENCY=2 request at cycle 0 → ready in cycle 2, new request accepted at cycle 4.
